wb_mem_arbiter: RTL and testbench

Four-requester arbiter in the user project that shares one memory port between the CPU Wishbone path and the FIR, matmul and quicksort DMA engines. Requester 1 (CPU) has priority. Requesters 2–4 (DMAs) are served round-robin, and a starvation guard forces a DMA grant after a bounded CPU streak. One transaction is in flight at a time. A timeout completes any access the memory never acknowledges.

---
 rtl/wb_mem_arb_pkg.sv | 12 +
 rtl/wb_mem_arbiter_rr_picker3.sv | 19 +
 rtl/wb_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_arb_pkg.sv
// wb_mem_arb_pkg: shared states, requester indices and helpers for the memory arbiter
package wb_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [2:0] REQ_CPU = 3'd1;
  localparam logic [2:0] REQ_FIR = 3'd2;
  localparam logic [2:0] REQ_MM  = 3'd3;
  localparam logic [2:0] REQ_QS  = 3'd4;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction
endpackage

// File: rtl/wb_mem_arbiter_rr_picker3.sv
// rr_picker3: round-robin pick among DMA requesters 2..4, starting after ptr
module rr_picker3
  import wb_mem_arb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [2:0] ptr,
  output logic [2:0] win,
  output logic       found
);
  logic [4:0] v;
  logic [2:0] c0, c1;
  always_comb begin
    v = {valid, 2'b00};
    c0 = (ptr == REQ_QS) ? REQ_FIR : ptr + 3'd1;
    c1 = (c0 == REQ_QS) ? REQ_FIR : c0 + 3'd1;
    win = v[c0] ? c0 : v[c1] ? c1 : v[ptr] ? ptr : 3'd0;
    found = |valid;
  end
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: CPU-priority, DMA round-robin arbiter onto a single memory port with timeout
module wb_mem_arbiter
  import wb_mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_1,
  input  logic [AW-1:0] addr_2,
  input  logic [AW-1:0] addr_3,
  input  logic [AW-1:0] addr_4,
  input  logic          rw_1,
  input  logic          rw_2,
  input  logic          rw_3,
  input  logic          rw_4,
  input  logic          valid_in_1,
  input  logic          valid_in_2,
  input  logic          valid_in_3,
  input  logic          valid_in_4,
  input  logic [DW-1:0] data_in_1,
  input  logic [DW-1:0] data_in_2,
  input  logic [DW-1:0] data_in_3,
  input  logic [DW-1:0] data_in_4,
  output logic          valid_out_1,
  output logic          valid_out_2,
  output logic          valid_out_3,
  output logic          valid_out_4,
  output logic [DW-1:0] data_out_1,
  output logic [DW-1:0] data_out_2,
  output logic [DW-1:0] data_out_3,
  output logic [DW-1:0] data_out_4,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [3:0]    grant,
  output logic          timeout_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] streak;
  logic [2:0] rr_ptr, dma_win, pick;
  logic [1:0] own;
  logic [3:0] vout;
  logic [DW-1:0] dout [4];
  logic dma_found, any_dma, starve, pick_cpu, go, sel_rw;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  rr_picker3 u_rr (
    .valid({valid_in_4, valid_in_3, valid_in_2}),
    .ptr(rr_ptr),
    .win(dma_win),
    .found(dma_found)
  );
  always_comb begin
    any_dma = valid_in_2 | valid_in_3 | valid_in_4;
    starve = (streak == SW'(STARVE_LIMIT)) && any_dma;
    pick_cpu = valid_in_1 && !starve;
    go = valid_in_1 || dma_found;
    pick = pick_cpu ? REQ_CPU : dma_win;
    sel_addr = (pick == REQ_CPU) ? addr_1 : (pick == REQ_FIR) ? addr_2 : (pick == REQ_MM) ? addr_3 : addr_4;
    sel_rw = (pick == REQ_CPU) ? rw_1 : (pick == REQ_FIR) ? rw_2 : (pick == REQ_MM) ? rw_3 : rw_4;
    sel_wdata = (pick == REQ_CPU) ? data_in_1 : (pick == REQ_FIR) ? data_in_2 : (pick == REQ_MM) ? data_in_3 : data_in_4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      own <= '0;
      tcnt <= '0;
      streak <= '0;
      rr_ptr <= REQ_QS;
      vout <= '0;
      timeout_err <= 1'b0;
      dout <= '{default: '0};
    end else begin
      vout <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state <= BUSY;
          own <= 2'(pick - 3'd1);
          grant <= onehot(2'(pick - 3'd1));
          mem_en <= 1'b1;
          mem_we <= sel_rw;
          mem_addr <= sel_addr;
          mem_wdata <= sel_wdata;
          if (pick_cpu)
            streak <= !any_dma ? '0 : (streak == SW'(STARVE_LIMIT)) ? streak : streak + 1'b1;
          else begin
            streak <= '0;
            rr_ptr <= dma_win;
          end
        end
        BUSY: begin
          tcnt <= tcnt + 1'b1;
          // ack takes precedence over a timeout landing in the same cycle
          if (mem_ack || tcnt == TW'(TIMEOUT - 1)) begin
            state <= RESP;
            mem_en <= 1'b0;
            grant <= '0;
            vout[own] <= 1'b1;
            timeout_err <= !mem_ack;
            if (!mem_ack) dout[own] <= DW'(ERR_DATA);
            else if (!mem_we) dout[own] <= mem_rdata;
          end
        end
        RESP: begin
          state <= IDLE;
          grant <= '0;
          tcnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign {valid_out_4, valid_out_3, valid_out_2, valid_out_1} = vout;
  assign data_out_1 = dout[0];
  assign data_out_2 = dout[1];
  assign data_out_3 = dout[2];
  assign data_out_4 = dout[3];
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed checks of priority, round-robin, starvation, timeout and reset
module tb_wb_mem_arbiter;
  logic clk, rst;
  logic [31:0] addr_1, addr_2, addr_3, addr_4;
  logic rw_1, rw_2, rw_3, rw_4;
  logic valid_in_1, valid_in_2, valid_in_3, valid_in_4;
  logic [31:0] data_in_1, data_in_2, data_in_3, data_in_4;
  logic valid_out_1, valid_out_2, valid_out_3, valid_out_4;
  logic [31:0] data_out_1, data_out_2, data_out_3, data_out_4;
  logic mem_en, mem_we, mem_ack, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] grant;
  int checks = 0, errors = 0;

  wb_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3), .addr_4(addr_4),
    .rw_1(rw_1), .rw_2(rw_2), .rw_3(rw_3), .rw_4(rw_4),
    .valid_in_1(valid_in_1), .valid_in_2(valid_in_2), .valid_in_3(valid_in_3), .valid_in_4(valid_in_4),
    .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3), .data_in_4(data_in_4),
    .valid_out_1(valid_out_1), .valid_out_2(valid_out_2), .valid_out_3(valid_out_3), .valid_out_4(valid_out_4),
    .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3), .data_out_4(data_out_4),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [3:0] g2 [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
  logic [31:0] d2 [6] = '{32'h2000_0002, 32'h3000_0003, 32'h4000_0004, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
  logic [3:0] g3 [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
  int en_cnt;

  initial begin
    rst = 1'b1;
    {addr_1, addr_2, addr_3, addr_4} = '0;
    {rw_1, rw_2, rw_3, rw_4} = '0;
    {valid_in_1, valid_in_2, valid_in_3, valid_in_4} = '0;
    {data_in_1, data_in_2, data_in_3, data_in_4} = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_vout", {valid_out_4, valid_out_3, valid_out_2, valid_out_1}, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_dout1", data_out_1, 0);
    chk("rst_maddr", mem_addr, 0);

    // CPU read, zero wait
    valid_in_1 = 1'b1; addr_1 = 32'h3800_0010; rw_1 = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk("cpu_t1_grant", grant, 4'b0001);
    chk("cpu_t1_en", mem_en, 1);
    chk("cpu_t1_addr", mem_addr, 32'h3800_0010);
    chk("cpu_t1_we", mem_we, 0);
    chk("cpu_t1_vout", valid_out_1, 0);
    tick();
    chk("cpu_t2_vout", valid_out_1, 1);
    chk("cpu_t2_data", data_out_1, 32'h1234_5678);
    chk("cpu_t2_grant", grant, 0);
    chk("cpu_t2_en", mem_en, 0);
    valid_in_1 = 1'b0;
    tick();
    chk("cpu_t3_vout", valid_out_1, 0);
    chk("cpu_t3_hold", data_out_1, 32'h1234_5678);

    // three DMAs writing continuously, round robin from pointer 4
    {rw_2, rw_3, rw_4} = 3'b111;
    data_in_2 = 32'h2000_0002; data_in_3 = 32'h3000_0003; data_in_4 = 32'h4000_0004;
    {valid_in_2, valid_in_3, valid_in_4} = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i), grant, g2[i]);
      chk($sformatf("rr_we%0d", i), mem_we, 1);
      chk($sformatf("rr_wdata%0d", i), mem_wdata, d2[i]);
      tick();
      chk($sformatf("rr_vout%0d", i), {valid_out_4, valid_out_3, valid_out_2, valid_out_1}, g2[i]);
      tick();
      chk($sformatf("rr_idle%0d", i), grant, 0);
    end
    {valid_in_2, valid_in_3, valid_in_4} = 3'b000;

    // CPU and DMA3 continuously valid: starvation guard
    rw_1 = 1'b0; rw_3 = 1'b0; mem_rdata = 32'hCAFE_0003;
    valid_in_1 = 1'b1; valid_in_3 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("st_grant%0d", i), grant, g3[i]);
      tick();
      chk($sformatf("st_vout%0d", i), {valid_out_4, valid_out_3, valid_out_2, valid_out_1}, g3[i]);
      tick();
    end
    chk("st_dout3", data_out_3, 32'hCAFE_0003);
    valid_in_1 = 1'b0; valid_in_3 = 1'b0;

    // DMA2 read with no ack: timeout
    mem_ack = 1'b0; rw_2 = 1'b0; addr_2 = 32'h0000_0200;
    valid_in_2 = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 300 && !valid_out_2; i++) begin
      tick();
      if (mem_en) en_cnt++;
    end
    chk("to_en_cycles", en_cnt, 255);
    chk("to_vout", valid_out_2, 1);
    chk("to_data", data_out_2, 32'hDEAD_BEEF);
    chk("to_err", timeout_err, 1);
    chk("to_en_resp", mem_en, 0);
    valid_in_2 = 1'b0;
    tick();
    chk("to_err_pulse", timeout_err, 0);
    chk("to_vout_pulse", valid_out_2, 0);

    // reset during BUSY of a CPU write
    valid_in_1 = 1'b1; rw_1 = 1'b1; data_in_1 = 32'h1111_0001;
    tick();
    chk("rb_busy_en", mem_en, 1);
    chk("rb_busy_grant", grant, 4'b0001);
    chk("rb_busy_we", mem_we, 1);
    rst = 1'b1;
    tick();
    chk("rb_rst_en", mem_en, 0);
    chk("rb_rst_grant", grant, 0);
    chk("rb_rst_dout1", data_out_1, 0);
    rst = 1'b0; valid_in_1 = 1'b0; mem_ack = 1'b1;
    tick();
    chk("rb_late_ack_vout", valid_out_1, 0);
    chk("rb_late_ack_en", mem_en, 0);
    chk("rb_late_ack_grant", grant, 0);
    rw_4 = 1'b0; addr_4 = 32'h0000_0400; mem_rdata = 32'h4444_0004;
    valid_in_4 = 1'b1;
    tick();
    chk("rb_dma4_grant", grant, 4'b1000);
    chk("rb_dma4_addr", mem_addr, 32'h0000_0400);
    tick();
    chk("rb_dma4_vout", valid_out_4, 1);
    chk("rb_dma4_data", data_out_4, 32'h4444_0004);
    valid_in_4 = 1'b0;
    tick();

    // DMA2 write then read
    rw_2 = 1'b1; data_in_2 = 32'h5555_AAAA; mem_rdata = 32'h2222_0002;
    valid_in_2 = 1'b1;
    tick();
    chk("wr_grant", grant, 4'b0010);
    chk("wr_wdata", mem_wdata, 32'h5555_AAAA);
    tick();
    chk("wr_vout", valid_out_2, 1);
    chk("wr_dout_unchanged", data_out_2, 0);
    valid_in_2 = 1'b0;
    tick();
    rw_2 = 1'b0; valid_in_2 = 1'b1;
    tick();
    chk("rd_we", mem_we, 0);
    tick();
    chk("rd_vout", valid_out_2, 1);
    chk("rd_dout", data_out_2, 32'h2222_0002);
    valid_in_2 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
